// File: rtl/dest_port_arbiter.sv
// dest_port_arbiter: round-robin grant scheduler for one destination port of
// the shared-memory switch. It picks one requesting input at a time and
// presents it to the write path over a valid/ready handshake.
// Optional feature macro: ARB_BURST_LOCK_EN. When it is defined, a grant stays
// locked on one input for up to MAX_BURST beats.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif

module dest_port_arbiter #(
  parameter int unsigned PORT_NUB  = `PORT_NUB_TOTAL,
  parameter int unsigned DEST      = 0,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned SEL_W    = $clog2(PORT_NUB)
) (
  input  logic                clk,
  input  logic                rst_n,      // synchronous, active-high
  input  logic [PORT_NUB-1:0] req,
  input  logic                wr_ready,
  output logic [PORT_NUB-1:0] gnt,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic [SEL_W-1:0]    gnt_dest,
  output logic                gnt_valid,
  output logic                gnt_last
);

  // Reject parameter values the scheduler cannot support
  if (PORT_NUB < 2) begin : g_bad_port_nub
    $error("dest_port_arbiter: PORT_NUB must be at least 2");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("dest_port_arbiter: MAX_BURST must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nx;
  logic [SEL_W-1:0]    rr_ptr, ptr_nx;
  logic [SEL_W-1:0]    idx_nx;
  logic [PORT_NUB-1:0] gnt_nx;
  logic                valid_nx;
  logic                last_nx;
  logic                rearb;
  logic [SEL_W-1:0]    arb_ptr;
  logic [SEL_W-1:0]    ptr_adv;
  logic                win_found;
  logic [SEL_W-1:0]    win_idx;
`ifdef ARB_BURST_LOCK_EN
  logic [7:0]          beat_cnt, beat_nx;
`endif

  assign gnt_dest = SEL_W'(DEST);

  // Pointer one past the current grant, wrapping modulo PORT_NUB
  assign ptr_adv = (gnt_idx == SEL_W'(PORT_NUB - 1)) ? '0 : SEL_W'(gnt_idx + 1'b1);

  // Rotating-priority search: first requester at or after arb_ptr, with wrap.
  // Scanning from the far end lets the closest hit overwrite earlier ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = int'(PORT_NUB) - 1; k >= 0; k--) begin
      int unsigned j;
      j = int'(arb_ptr) + k;
      if (j >= PORT_NUB) j = j - PORT_NUB;
      if (req[j]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'(j);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    ptr_nx   = rr_ptr;
    idx_nx   = gnt_idx;
    valid_nx = gnt_valid;
    last_nx  = gnt_last;
    rearb    = 1'b0;
    arb_ptr  = rr_ptr;
`ifdef ARB_BURST_LOCK_EN
    beat_nx  = beat_cnt;
`endif

    case (state)
      IDLE: begin
        if (|req) rearb = 1'b1;
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
`ifdef ARB_BURST_LOCK_EN
          // A burst cut short after real beats still counts as served
          if (beat_cnt != 8'd0) begin
            ptr_nx  = ptr_adv;
            arb_ptr = ptr_adv;
            rearb   = 1'b1;
          end else
`endif
          begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            idx_nx   = '0;
            last_nx  = 1'b0;
          end
        end else if (wr_ready) begin
`ifdef ARB_BURST_LOCK_EN
          if (gnt_last) begin
            ptr_nx  = ptr_adv;
            arb_ptr = ptr_adv;
            rearb   = 1'b1;
          end else begin
            beat_nx = 8'(beat_cnt + 8'd1);
            last_nx = (8'(beat_cnt + 8'd1) == 8'(MAX_BURST - 1));
          end
`else
          ptr_nx  = ptr_adv;
          arb_ptr = ptr_adv;
          rearb   = 1'b1;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase

    if (rearb) begin
`ifdef ARB_BURST_LOCK_EN
      beat_nx = 8'd0;
`endif
      if (win_found) begin
        state_nx = GRANT;
        valid_nx = 1'b1;
        idx_nx   = win_idx;
`ifdef ARB_BURST_LOCK_EN
        last_nx  = (MAX_BURST == 1);
`else
        last_nx  = 1'b1;
`endif
      end else begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        idx_nx   = '0;
        last_nx  = 1'b0;
      end
    end

    gnt_nx = valid_nx ? (PORT_NUB'(1) << idx_nx) : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt_last  <= 1'b0;
`ifdef ARB_BURST_LOCK_EN
      beat_cnt  <= 8'd0;
`endif
    end else begin
      state     <= state_nx;
      rr_ptr    <= ptr_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      gnt_last  <= last_nx;
`ifdef ARB_BURST_LOCK_EN
      beat_cnt  <= beat_nx;
`endif
    end
  end

endmodule
